// File: rtl/display_value_queue.sv
// Display value queue: buffers signed results and shows each for a minimum hold time.
// Latency: a value accepted into an empty queue with an expired hold appears one edge later.
// Backpressure: in_ready drops when the FIFO is full or clear is high; a pop reopens it next cycle.
module display_value_queue #(
  parameter int VALUE_W     = 16,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [VALUE_W-1:0]         in_value,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       clear,
  output logic [VALUE_W-1:0]         value,
  output logic                       print_it,
  output logic [$clog2(DEPTH+1)-1:0] pending
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [VALUE_W-1:0]   r_mem [DEPTH];
  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic [TW-1:0]        r_timer;
  logic [VALUE_W-1:0]   r_value;
  logic                 r_print;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_not_empty;
  logic                 w_in_ready;

  // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot early.
  assign w_in_ready  = (r_count != FULL_COUNT) && !clear;
  assign w_push      = in_valid && w_in_ready;
  assign w_not_empty = (r_count != '0);

  assign in_ready = w_in_ready;
  assign value    = r_value;
  assign print_it = r_print;
  assign pending  = r_count;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and pop decision; clear wins over any scheduled pop.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_not_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if ((r_timer == '0) && w_not_empty) begin
          w_pop = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (clear) begin
      w_pop       = 1'b0;
      w_state_nxt = ST_IDLE;
    end
  end

  // FIFO storage; contents are don't-care while the count says empty, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_value;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap by overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Display register and hold timer: load on pop, otherwise count down to zero and stay there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
      r_print <= 1'b0;
      r_timer <= '0;
    end else if (clear) begin
      r_value <= '0;
      r_print <= 1'b0;
      r_timer <= '0;
    end else if (w_pop) begin
      r_value <= r_mem[r_rptr];
      r_print <= 1'b1;
      r_timer <= HOLD_LOAD;
    end else if ((r_state == ST_SHOW) && (r_timer != '0)) begin
      r_timer <= r_timer - TW'(1);
    end
  end

endmodule

// File: tb/tb_display_value_queue.sv
// Directed bench for display_value_queue with DEPTH=4, HOLD_CYCLES=4, VALUE_W=16.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Each scenario task starts from a fresh reset and checks against hand-derived values.
module tb_display_value_queue;

  localparam int VW    = 16;
  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  logic          clk      = 1'b0;
  logic          clk_en   = 1'b0;
  logic          rst_n    = 1'b0;
  logic [VW-1:0] in_value = '0;
  logic          in_valid = 1'b0;
  logic          clear    = 1'b0;
  logic          in_ready;
  logic [VW-1:0] value;
  logic          print_it;
  logic [2:0]    pending;

  int checks = 0;
  int errors = 0;

  display_value_queue #(
    .VALUE_W    (VW),
    .DEPTH      (DEPTH),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_value (in_value),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .clear    (clear),
    .value    (value),
    .print_it (print_it),
    .pending  (pending)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    clear    = 1'b0;
    rst_n    = 1'b0;
    #2;
    rst_n    = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    clk_en = 1'b0;
    #2;
    checks++; if (value !== 16'h0000) begin errors++; $display("FAIL reset_value: got %h want 0000", value); end
    checks++; if (print_it !== 1'b0) begin errors++; $display("FAIL reset_print: got %b want 0", print_it); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL reset_pending: got %0d want 0", pending); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst_n  = 1'b1;
    #2;
    clk_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (value !== 16'h0000 || print_it !== 1'b0 || pending !== 3'd0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_idle cyc%0d: value=%h print=%b pending=%0d rdy=%b want 0000/0/0/1", i, value, print_it, pending, in_ready);
      end
    end
  endtask

  task automatic test_single();
    apply_reset();
    in_value = 16'hFF85;
    in_valid = 1'b1;
    step(); // edge 0: accepted
    in_valid = 1'b0;
    checks++; if (print_it !== 1'b0) begin errors++; $display("FAIL single_not_same_cycle: print=%b want 0", print_it); end
    checks++; if (pending !== 3'd1) begin errors++; $display("FAIL single_pending_e0: got %0d want 1", pending); end
    step(); // edge 1: shown
    checks++; if (value !== 16'hFF85) begin errors++; $display("FAIL single_value_e1: got %h want ff85", value); end
    checks++; if (print_it !== 1'b1) begin errors++; $display("FAIL single_print_e1: got %b want 1", print_it); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL single_pending_e1: got %0d want 0", pending); end
    for (int i = 0; i < 22; i++) begin
      step();
      checks++; if (value !== 16'hFF85 || print_it !== 1'b1) begin
        errors++;
        $display("FAIL single_persist cyc%0d: value=%h print=%b want ff85/1", i, value, print_it);
      end
    end
  endtask

  task automatic test_burst();
    int            exp_pend;
    logic [VW-1:0] exp_val;
    logic          exp_print;
    logic          exp_rdy;
    int            k;
    apply_reset();
    exp_pend = 0;
    for (int e = 0; e <= 25; e++) begin
      if (e <= 4) begin
        in_valid = 1'b1;
        in_value = 16'(e + 1);
      end else begin
        in_valid = 1'b0;
      end
      step(); // edge e
      if (e <= 4) exp_pend++;
      if (e == 1 || (e >= 5 && e <= 17 && ((e - 5) % 4) == 0)) exp_pend--;
      exp_rdy = (e == 4) ? 1'b0 : 1'b1;
      if (e == 0) begin
        exp_val   = 16'd0;
        exp_print = 1'b0;
      end else if (e < 5) begin
        exp_val   = 16'd1;
        exp_print = 1'b1;
      end else begin
        k = (e - 5) / 4 + 2;
        if (k > 5) k = 5;
        exp_val   = 16'(k);
        exp_print = 1'b1;
      end
      checks++; if (value !== exp_val) begin errors++; $display("FAIL burst_value e%0d: got %h want %h", e, value, exp_val); end
      checks++; if (print_it !== exp_print) begin errors++; $display("FAIL burst_print e%0d: got %b want %b", e, print_it, exp_print); end
      checks++; if (pending !== 3'(exp_pend)) begin errors++; $display("FAIL burst_pending e%0d: got %0d want %0d", e, pending, exp_pend); end
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL burst_in_ready e%0d: got %b want %b", e, in_ready, exp_rdy); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_expired();
    apply_reset();
    in_value = 16'd7;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    checks++; if (value !== 16'd7) begin errors++; $display("FAIL expired_first: got %h want 0007", value); end
    repeat (10) step();
    in_value = 16'd8;
    in_valid = 1'b1;
    step(); // edge K
    in_valid = 1'b0;
    checks++; if (value !== 16'd7 || pending !== 3'd1) begin
      errors++;
      $display("FAIL expired_eK: value=%h pending=%0d want 0007/1", value, pending);
    end
    step(); // edge K+1
    checks++; if (value !== 16'd8 || print_it !== 1'b1 || pending !== 3'd0) begin
      errors++;
      $display("FAIL expired_eK1: value=%h print=%b pending=%0d want 0008/1/0", value, print_it, pending);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (value !== 16'd8) begin errors++; $display("FAIL expired_hold cyc%0d: got %h want 0008", i, value); end
    end
  endtask

  task automatic test_clear();
    apply_reset();
    for (int v = 1; v <= 4; v++) begin
      in_value = 16'(v);
      in_valid = 1'b1;
      step(); // edges 0..3
    end
    in_valid = 1'b0;
    step(); // edge 4
    step(); // edge 5: 2 shown, 3 and 4 pending
    checks++; if (value !== 16'd2 || pending !== 3'd2) begin
      errors++;
      $display("FAIL clear_setup: value=%h pending=%0d want 0002/2", value, pending);
    end
    clear    = 1'b1;
    in_valid = 1'b1;
    in_value = 16'd9;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready: got %b want 0", in_ready); end
    step(); // edge 6: clear sampled
    clear = 1'b0;
    checks++; if (value !== 16'd0 || print_it !== 1'b0 || pending !== 3'd0) begin
      errors++;
      $display("FAIL clear_result: value=%h print=%b pending=%0d want 0000/0/0", value, print_it, pending);
    end
    step(); // edge 7: 9 accepted
    in_valid = 1'b0;
    checks++; if (pending !== 3'd1 || print_it !== 1'b0) begin
      errors++;
      $display("FAIL clear_repush: pending=%0d print=%b want 1/0", pending, print_it);
    end
    step(); // edge 8: 9 shown
    checks++; if (value !== 16'd9 || print_it !== 1'b1) begin
      errors++;
      $display("FAIL clear_show9: value=%h print=%b want 0009/1", value, print_it);
    end
  endtask

  task automatic test_async_reset();
    int guard;
    apply_reset();
    for (int v = 1; v <= 6; v++) begin
      in_value = 16'(v);
      in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 20) begin
        step();
        guard++;
      end
      step();
    end
    in_valid = 1'b0;
    guard = 0;
    while (value !== 16'd3 && guard < 40) begin
      step();
      guard++;
    end
    checks++; if (value !== 16'd3) begin errors++; $display("FAIL async_wait_show3: timed out, value=%h want 0003", value); end
    checks++; if (pending !== 3'd3) begin errors++; $display("FAIL async_setup_pending: got %0d want 3", pending); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (value !== 16'd0 || print_it !== 1'b0 || pending !== 3'd0) begin
      errors++;
      $display("FAIL async_reset_now: value=%h print=%b pending=%0d want 0000/0/0", value, print_it, pending);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_rdy: got %b want 1", in_ready); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++; if (print_it !== 1'b0 || pending !== 3'd0 || value !== 16'd0) begin
        errors++;
        $display("FAIL async_after_release cyc%0d: value=%h print=%b pending=%0d want 0000/0/0", i, value, print_it, pending);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_expired();
    test_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
